zx_sram_arbiter: RTL and testbench
==================================

// Module: zx_sram_arbiter
// PURPOSE
//  Parametrised N-channel arbiter for the shared video/system SRAM (va/vd, n_vrd/n_vwr).
//  Serialises requests from video fetch, CPU and auxiliary masters (SD/DMA) into fixed-length SRAM cycles.
//  Each access returns a per-channel grant and acknowledge.
//  Sits between zx_ula bus decode and the SRAM pins. Replaces hard-wired single-master va/vd steering.
// PARAMETERS
//  CHANNELS       3   number of requesters, >=1; index 0 = highest fixed priority
//  AW             19  SRAM address width (va)
//  DW             8   SRAM data width (vd)
//  ACCESS_CYCLES  4   clk28 cycles per SRAM access, >=3
// PORTS
//  clk28    in   1            system clock; all logic on posedge
//  rst_n    in   1            asynchronous active-low reset
//  req      in   CHANNELS     per-channel request; held high until gnt seen
//  we       in   CHANNELS     per-channel write enable (1=write, 0=read), valid with req
//  addr     in   CHANNELS*AW  per-channel address, slice [i*AW +: AW]
//  wdata    in   CHANNELS*DW  per-channel write data, slice [i*DW +: DW]
//  gnt      out  CHANNELS     one-hot, 1-cycle pulse: request accepted, req/addr/wdata latched
//  ack      out  CHANNELS     one-hot, 1-cycle pulse: access complete, rdata valid (reads)
//  rdata    out  DW           read data, stable from ack until next read ack
//  busy     out  1            high while an access is in progress
//  va       out  AW           SRAM address
//  vd_o     out  DW           SRAM write data
//  vd_oe    out  1            SRAM data output enable (top-level tristates vd)
//  vd_i     in   DW           SRAM read data
//  n_vrd    out  1            SRAM read strobe, active low
//  n_vwr    out  1            SRAM write strobe, active low
// BEHAVIOUR
//  - Reset values: gnt=0, ack=0, rdata=0, busy=0, va=0, vd_o=0, vd_oe=0, n_vrd=1, n_vwr=1, cnt=0, rr pointer=0.
//  - FSM: IDLE, ACCESS. A 2-bit-or-wider counter cnt runs 0..ACCESS_CYCLES-1 in ACCESS.
//  - Arbitration happens at a posedge in IDLE with |req, or at the posedge ending the last ACCESS cycle with |req.
//  - At arbitration, the winner's we/addr/wdata are latched, gnt[winner]=1 for the next cycle, state=ACCESS, cnt=0.
//  - No idle bubble between back-to-back accesses.
//  - All SRAM outputs are registered; va holds the latched address for the whole access.
//  - Read access: n_vrd=0 for cnt 0..ACCESS_CYCLES-1.
//    vd_i is captured into rdata at the posedge ending cnt=ACCESS_CYCLES-1.
//  - Write access: vd_oe=1 and vd_o=wdata for all cnt.
//    n_vwr=0 only for cnt 1..ACCESS_CYCLES-2, giving 1 cycle of address/data setup and 1 cycle of hold.
//  - ack[winner]=1 for the single cycle after the last ACCESS cycle.
//    If a new arbitration occurs on that edge, the old ack and the new gnt coincide; busy stays 1.
//  - Return to IDLE: after the last cycle with no req, busy=0, n_vrd=n_vwr=1, vd_oe=0; va holds its last value.
//  - Requester contract: drop req (or change to a new request) no later than the edge after gnt.
//    Since ACCESS_CYCLES>=3, a dropped req is never re-granted. A req still high at the end of an access is a new request.
//  - Requests that rise mid-access wait. req changes mid-access do not affect the current access.
//  - Asynchronous reset mid-access: all outputs go to reset values immediately.
//    The access is abandoned and no ack is issued.
//  - CHANNELS=1: grant logic degenerates to req[0]; behaviour otherwise identical.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    Round-robin. The search starts at (last winner + 1) mod CHANNELS; the pointer updates on every grant.
//    No channel waits more than CHANNELS-1 accesses.
//  ARB_ROUND_ROBIN_EN undefined:
//    Fixed priority, lowest index wins. A continuously requesting channel 0 may starve higher indices (intended for video).
// TESTING
//  1 Read, ch1, addr=19'h12345, SRAM model returns 8'hA5:
//    gnt=3'b010 for 1 cycle, va=19'h12345, n_vrd low 4 cycles, then ack=3'b010, rdata=8'hA5.
//  2 Write, ch2, addr=19'h00100, wdata=8'h5A:
//    vd_oe high for cnt 0-3, n_vwr low for cnt 1-2 only, vd_o=8'h5A; ack=3'b100; model mem[0x100]=8'h5A.
//  3 req=3'b111 in the same cycle, each channel drops req after its gnt:
//    grant order 0,1,2; three accesses back-to-back; busy high 12 cycles.
//  4 ch0 re-requests continuously, ch2 requests too:
//    fixed priority => ch2 never granted in 10 accesses; with ARB_ROUND_ROBIN_EN => grants alternate 0,2,0,2.
//  5 rst_n low at cnt=1 of a write:
//    n_vwr=1, vd_oe=0, busy=0 in the same cycle; no ack; after release a fresh req is granted normally.
//  6 CHANNELS=1, ACCESS_CYCLES=3, write:
//    n_vwr low for exactly 1 cycle (cnt=1); read after it returns the written data.

Source files
------------

// File: rtl/zx_sram_arbiter.sv
// Shared video/system SRAM arbiter: serialises CHANNELS masters into fixed-length SRAM cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority, index 0 highest.
module zx_sram_arbiter #(
    parameter int CHANNELS      = 3,
    parameter int AW            = 19,
    parameter int DW            = 8,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                   clk28,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    req,
    input  logic [CHANNELS-1:0]    we,
    input  logic [CHANNELS*AW-1:0] addr,
    input  logic [CHANNELS*DW-1:0] wdata,
    output logic [CHANNELS-1:0]    gnt,
    output logic [CHANNELS-1:0]    ack,
    output logic [DW-1:0]          rdata,
    output logic                   busy,
    output logic [AW-1:0]          va,
    output logic [DW-1:0]          vd_o,
    output logic                   vd_oe,
    input  logic [DW-1:0]          vd_i,
    output logic                   n_vrd,
    output logic                   n_vwr
);
    localparam int CW = ($clog2(ACCESS_CYCLES) < 2) ? 2 : $clog2(ACCESS_CYCLES);
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [PW-1:0] cur_idx;
    logic [PW-1:0] win_idx;
    logic          cur_we;
    logic          last_cycle;
    logic          arb;
`ifdef ARB_ROUND_ROBIN_EN
    logic [PW-1:0] rr_ptr;
    logic          rr_found;
`endif

    assign last_cycle = (state == ACCESS) && (cnt == LAST_CNT);

    always_comb begin : winner_select
        win_idx = '0;
`ifdef ARB_ROUND_ROBIN_EN
        // Search starts one past the previous winner and wraps.
        rr_found = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!rr_found && req[PW'((int'(rr_ptr) + k) % CHANNELS)]) begin
                rr_found = 1'b1;
                win_idx  = PW'((int'(rr_ptr) + k) % CHANNELS);
            end
        end
`else
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req[PW'(k)]) win_idx = PW'(k);
        end
`endif
    end

    always_comb begin : fsm_next
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        arb       = 1'b0;
        state_nxt = state;
        if ((state == IDLE || last_cycle) && |req) begin
            arb       = 1'b1;
            state_nxt = ACCESS;
        end else if (last_cycle) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin : fsm_state
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin : datapath
        if (!rst_n) begin
            cnt     <= '0;
            cur_idx <= '0;
            cur_we  <= 1'b0;
            gnt     <= '0;
            ack     <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            va      <= '0;
            vd_o    <= '0;
            vd_oe   <= 1'b0;
            n_vrd   <= 1'b1;
            n_vwr   <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr  <= '0;
`endif
        end else begin
            gnt <= '0;
            ack <= '0;
            if (last_cycle) begin
                ack[cur_idx] <= 1'b1;
                if (!cur_we) rdata <= vd_i;
            end
            if (arb) begin
                // Winner's request is latched straight into the SRAM pin registers.
                cnt          <= '0;
                cur_idx      <= win_idx;
                cur_we       <= we[win_idx];
                gnt[win_idx] <= 1'b1;
                busy         <= 1'b1;
                va           <= addr[win_idx*AW +: AW];
                vd_o         <= wdata[win_idx*DW +: DW];
                vd_oe        <= we[win_idx];
                n_vrd        <= we[win_idx];
                n_vwr        <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                rr_ptr       <= win_idx;
`endif
            end else if (last_cycle) begin
                cnt   <= '0;
                busy  <= 1'b0;
                vd_oe <= 1'b0;
                n_vrd <= 1'b1;
                n_vwr <= 1'b1;
            end else if (state == ACCESS) begin
                cnt   <= cnt + 1'b1;
                // Write strobe skips the first and last cycle for address/data setup and hold.
                n_vwr <= !(cur_we && (int'(cnt) + 1 <= ACCESS_CYCLES - 2));
            end
        end
    end
endmodule

// File: tb/tb_zx_sram_arbiter.sv
// Self-checking bench for zx_sram_arbiter: directed vectors, corner sequences and a random model run.
// Honours ARB_ROUND_ROBIN_EN when selecting expected grant order.
module tb_zx_sram_arbiter;
    localparam int CH = 3, AW = 19, DW = 8, AC = 4;

    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk28 = ~clk28;

    logic [CH-1:0]    req = '0, we = '0, gnt, ack;
    logic [CH*AW-1:0] addr = '0;
    logic [CH*DW-1:0] wdata = '0;
    logic [DW-1:0]    rdata, vd_o, vd_i;
    logic [AW-1:0]    va;
    logic             busy, vd_oe, n_vrd, n_vwr;

    zx_sram_arbiter #(.CHANNELS(CH), .AW(AW), .DW(DW), .ACCESS_CYCLES(AC)) u_dut (
        .clk28(clk28), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .va(va), .vd_o(vd_o),
        .vd_oe(vd_oe), .vd_i(vd_i), .n_vrd(n_vrd), .n_vwr(n_vwr));

    logic [0:0]    req1 = '0, we1 = '0, gnt1, ack1;
    logic [AW-1:0] addr1 = '0, va1;
    logic [DW-1:0] wdata1 = '0, rdata1, vd1_o, vd1_i;
    logic          busy1, vd1_oe, n_vrd1, n_vwr1;

    zx_sram_arbiter #(.CHANNELS(1), .AW(AW), .DW(DW), .ACCESS_CYCLES(3)) u_dut1 (
        .clk28(clk28), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .gnt(gnt1), .ack(ack1), .rdata(rdata1), .busy(busy1), .va(va1), .vd_o(vd1_o),
        .vd_oe(vd1_oe), .vd_i(vd1_i), .n_vrd(n_vrd1), .n_vwr(n_vwr1));

    // SRAM models: unwritten locations return a pattern derived from the address.
    logic [7:0] mem [int];
    logic [7:0] mem1 [int];
    function automatic logic [7:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    always @(negedge clk28) begin
        if (!n_vwr && vd_oe) mem[int'(va)] = vd_o;
        vd_i = n_vrd ? 8'hEE : (mem.exists(int'(va)) ? mem[int'(va)] : dflt(va));
        if (!n_vwr1 && vd1_oe) mem1[int'(va1)] = vd1_o;
        vd1_i = n_vrd1 ? 8'hEE : (mem1.exists(int'(va1)) ? mem1[int'(va1)] : dflt(va1));
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [CH-1:0] e_gnt, e_ack;
    logic          e_busy, e_vd_oe, e_n_vrd, e_n_vwr;
    logic [AW-1:0] e_va;
    logic [DW-1:0] e_vd_o, e_rdata;
    bit            m_active, m_we;
    int            m_start, m_ch, m_last_win, cyc;
    logic [AW-1:0] m_addr;
    logic [7:0]    mem_model [int];

    function automatic int pick(input logic [CH-1:0] r, input int last);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= CH; k++) if (r[(last + k) % CH]) return (last + k) % CH;
`else
        for (int k = 0; k < CH; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        e_gnt = '0; e_ack = '0; e_busy = 0; e_vd_oe = 0; e_n_vrd = 1; e_n_vwr = 1;
        e_va = '0; e_vd_o = '0; e_rdata = '0;
        m_active = 0; m_we = 0; m_start = 0; m_ch = 0; m_last_win = 0; cyc = 0; m_addr = '0;
    endtask

    // Advance the model across one rising edge using the requests currently driven.
    task automatic model_step();
        bit last_now;
        int w, off;
        last_now = m_active && (cyc - m_start == AC - 1);
        e_gnt = '0;
        e_ack = '0;
        if (last_now) begin
            e_ack[m_ch] = 1'b1;
            if (!m_we) e_rdata = mem_model.exists(int'(m_addr)) ? mem_model[int'(m_addr)] : dflt(m_addr);
        end
        if ((!m_active || last_now) && |req) begin
            w = pick(req, m_last_win);
            m_active = 1; m_start = cyc + 1; m_ch = w; m_last_win = w;
            m_we = we[w]; m_addr = addr[w*AW +: AW];
            e_gnt[w] = 1'b1;
            e_va = m_addr;
            if (m_we) begin
                e_vd_o = wdata[w*DW +: DW];
                mem_model[int'(m_addr)] = e_vd_o;
            end
        end else if (last_now) begin
            m_active = 0;
        end
        cyc++;
        off = cyc - m_start;
        e_busy  = m_active;
        e_n_vrd = !(m_active && !m_we);
        e_vd_oe = m_active && m_we;
        e_n_vwr = !(m_active && m_we && off >= 1 && off <= AC - 2);
    endtask

    task automatic compare_all();
        check("rnd_gnt", gnt, e_gnt);
        check("rnd_ack", ack, e_ack);
        check("rnd_busy", busy, e_busy);
        check("rnd_va", va, e_va);
        check("rnd_n_vrd", n_vrd, e_n_vrd);
        check("rnd_n_vwr", n_vwr, e_n_vwr);
        check("rnd_vd_oe", vd_oe, e_vd_oe);
        if (e_vd_oe) check("rnd_vd_o", vd_o, e_vd_o);
        check("rnd_rdata", rdata, e_rdata);
    endtask

    task automatic new_params(input int c);
        we[c]             = 1'($urandom_range(0, 1));
        addr[c*AW +: AW]  = AW'($urandom_range(0, 15));
        wdata[c*DW +: DW] = DW'($urandom);
    endtask

    // ---------------- directed single accesses ----------------
    typedef struct {
        int            ch;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
    } vec_t;
    vec_t vecs [5];

    task automatic single_access(input vec_t v);
        int rd_lo, wr_lo, oe_hi, busy_hi, wait_c;
        bit wr_pos_ok, wd_ok;
        logic [CH-1:0] oh;
        rd_lo = 0; wr_lo = 0; oe_hi = 0; busy_hi = 0; wait_c = 0; wr_pos_ok = 1; wd_ok = 1;
        oh = '0; oh[v.ch] = 1'b1;
        @(negedge clk28);
        req[v.ch] = 1'b1; we[v.ch] = v.wr;
        addr[v.ch*AW +: AW] = v.a; wdata[v.ch*DW +: DW] = v.wd;
        do begin @(negedge clk28); wait_c++; end while (gnt == '0 && wait_c < 8);
        check("gnt_latency", wait_c, 1);
        check("gnt", gnt, oh);
        check("va", va, v.a);
        req[v.ch] = 1'b0;
        for (int o = 0; o < AC; o++) begin
            if (o > 0) @(negedge clk28);
            if (!n_vrd) rd_lo++;
            if (!n_vwr) begin
                wr_lo++;
                if (o < 1 || o > AC - 2) wr_pos_ok = 0;
            end
            if (vd_oe) begin
                oe_hi++;
                if (vd_o !== v.wd) wd_ok = 0;
            end
            if (busy) busy_hi++;
        end
        @(negedge clk28);
        check("ack", ack, oh);
        check("busy_after", busy, 0);
        check("busy_cycles", busy_hi, AC);
        check("n_vrd_cycles", rd_lo, v.wr ? 0 : AC);
        check("n_vwr_cycles", wr_lo, v.wr ? AC - 2 : 0);
        check("n_vwr_window", wr_pos_ok, 1);
        check("vd_oe_cycles", oe_hi, v.wr ? AC : 0);
        check("vd_o_value", wd_ok, 1);
        if (v.wr) check("sram_written", mem.exists(int'(v.a)) ? mem[int'(v.a)] : 8'hxx, v.wd);
        else      check("rdata", rdata, v.exp_rd);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ng, busy_cnt, n_g, g2, t, waitc, wl, rl, wpos;
        int g_cyc [4];
        logic [CH-1:0] g_oh [4];
        logic [CH-1:0] prev;
        bit alt_ok;

        vecs[0] = '{1, 1'b0, 19'h12345, 8'h00, 8'hA5};
        vecs[1] = '{2, 1'b1, 19'h00100, 8'h5A, 8'h00};
        vecs[2] = '{0, 1'b0, 19'h00100, 8'h00, 8'h5A};
        vecs[3] = '{1, 1'b1, 19'h7FFFF, 8'hC3, 8'h00};
        vecs[4] = '{2, 1'b0, 19'h7FFFF, 8'h00, 8'hC3};
        mem[int'(19'h12345)] = 8'hA5;

        // Reset state
        @(negedge clk28);
        check("rst_gnt", gnt, 0);   check("rst_ack", ack, 0);   check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0); check("rst_va", va, 0);     check("rst_vd_o", vd_o, 0);
        check("rst_vd_oe", vd_oe, 0); check("rst_n_vrd", n_vrd, 1); check("rst_n_vwr", n_vwr, 1);
        check("rst1_busy", busy1, 0); check("rst1_n_vwr", n_vwr1, 1);
        @(negedge clk28);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) single_access(vecs[i]);

        // Simultaneous requests, each channel drops after its grant
        @(negedge clk28);
        req = 3'b111; we = 3'b000;
        addr = {19'h00003, 19'h00002, 19'h00001};
        ng = 0; busy_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk28);
            if (busy) busy_cnt++;
            if (gnt != '0) begin
                if (ng < 4) begin g_oh[ng] = gnt; g_cyc[ng] = c; end
                ng++;
                req = req & ~gnt;
            end
        end
        check("t3_grant_count", ng, 3);
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_all_granted", g_oh[0] | g_oh[1] | g_oh[2], 3'b111);
`else
        check("t3_first", g_oh[0], 3'b001);
        check("t3_second", g_oh[1], 3'b010);
        check("t3_third", g_oh[2], 3'b100);
`endif
        check("t3_gap01", g_cyc[1] - g_cyc[0], AC);
        check("t3_gap12", g_cyc[2] - g_cyc[1], AC);
        check("t3_busy_cycles", busy_cnt, 3 * AC);

        // Channel 0 requests continuously alongside channel 2
        @(negedge clk28);
        req = 3'b101; we = 3'b000;
        addr = {19'h00020, 19'h00000, 19'h00010};
        n_g = 0; g2 = 0; t = 0; prev = '0; alt_ok = 1;
        while (n_g < 10 && t < 80) begin
            @(negedge clk28);
            t++;
            if (gnt != '0) begin
                n_g++;
                if (gnt == 3'b100) g2++;
                if (gnt == prev) alt_ok = 0;
                prev = gnt;
            end
        end
        req = '0;
        check("t4_grants", n_g, 10);
`ifdef ARB_ROUND_ROBIN_EN
        check("t4_ch2_grants", g2, 5);
        check("t4_alternate", alt_ok, 1);
`else
        check("t4_ch2_grants", g2, 0);
`endif
        t = 0;
        while (busy && t < 20) begin @(negedge clk28); t++; end
        check("t4_drain", busy, 0);

        // Asynchronous reset in the middle of a write
        @(negedge clk28);
        req[2] = 1'b1; we[2] = 1'b1; addr[2*AW +: AW] = 19'h00077; wdata[2*DW +: DW] = 8'h77;
        waitc = 0;
        do begin @(negedge clk28); waitc++; end while (gnt == '0 && waitc < 8);
        check("t5_gnt", gnt, 3'b100);
        req = '0;
        @(negedge clk28);
        check("t5_strobe_before", n_vwr, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_n_vwr", n_vwr, 1); check("t5_vd_oe", vd_oe, 0); check("t5_busy", busy, 0);
        check("t5_n_vrd", n_vrd, 1); check("t5_va", va, 0);       check("t5_vd_o", vd_o, 0);
        check("t5_rdata", rdata, 0); check("t5_gnt_clr", gnt, 0); check("t5_ack_clr", ack, 0);
        @(negedge clk28);
        rst_n = 1'b1;
        t = 0;
        for (int c = 0; c < 6; c++) begin @(negedge clk28); if (ack != '0) t++; end
        check("t5_no_ack", t, 0);
        single_access(vecs[0]);

        // Single-channel instance, 3-cycle access: write then read back
        for (int op = 0; op < 2; op++) begin
            @(negedge clk28);
            req1 = 1'b1; we1 = (op == 0); addr1 = 19'h00042; wdata1 = 8'h96;
            waitc = 0;
            do begin @(negedge clk28); waitc++; end while (gnt1 == '0 && waitc < 8);
            check("c1_gnt_latency", waitc, 1);
            req1 = 1'b0; wl = 0; rl = 0; wpos = -1;
            for (int o = 0; o < 3; o++) begin
                if (o > 0) @(negedge clk28);
                if (!n_vwr1) begin wl++; wpos = o; end
                if (!n_vrd1) rl++;
            end
            @(negedge clk28);
            check("c1_ack", ack1, 1);
            if (op == 0) begin
                check("c1_n_vwr_cycles", wl, 1);
                check("c1_n_vwr_pos", wpos, 1);
            end else begin
                check("c1_n_vrd_cycles", rl, 3);
                check("c1_rdata", rdata1, 8'h96);
            end
        end

        // Random traffic against the reference model
        @(negedge clk28);
        rst_n = 1'b0; req = '0; we = '0;
        @(negedge clk28);
        mem.delete();
        mem_model.delete();
        rst_n = 1'b1;
        model_reset();
        model_step();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk28);
            compare_all();
            for (int c = 0; c < CH; c++) begin
                if (e_gnt[c]) begin
                    req[c] = ($urandom_range(0, 3) == 0);
                    if (req[c]) new_params(c);
                end else if (!req[c] && $urandom_range(0, 3) == 0) begin
                    req[c] = 1'b1;
                    new_params(c);
                end
            end
            model_step();
        end
        for (int i = 0; i < 3 * AC + 4; i++) begin
            @(negedge clk28);
            compare_all();
            for (int c = 0; c < CH; c++) if (e_gnt[c]) req[c] = 1'b0;
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
